exp2k_mul_seq: RTL and testbench



---
 rtl/exp2k_mul_seq.sv | 158 +++++++++++++++
 tb/tb_exp2k_mul_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp2k_mul_seq.sv
// exp2k_mul_seq: sequencer computing R = X^(2^K) * Y in GF(2^163) by driving
// the acb multiply/square unit over its enable/done handshake. K squarings are
// issued first (cfg=0, B=1), then a single multiply by Y (cfg=1).
module exp2k_mul_seq #(
  parameter int M        = 163,
  parameter int KW       = 8,
  parameter int WAIT_MAX = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [M-1:0]  x_in,
  input  logic [M-1:0]  y_in,
  input  logic [KW-1:0] k_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [M-1:0]  result,
  output logic [M-1:0]  mul_a,
  output logic [M-1:0]  mul_b,
  output logic          mul_enable,
  output logic          mul_cfg,
  input  logic [M-1:0]  mul_c,
  input  logic          mul_done
);

  localparam int            TW      = $clog2(WAIT_MAX + 1);
  localparam logic [M-1:0]  ONE     = M'(1);
  // err is registered, so it must be scheduled one cycle early; the WAIT state
  // starts one cycle after the enable pulse with timer=0, which puts the err
  // pulse exactly WAIT_MAX cycles after the enable.
  localparam logic [TW-1:0] TO_LAST = TW'(WAIT_MAX - 2);
  localparam logic [KW-1:0] K_ONE   = KW'(1);

  typedef enum logic [2:0] {
    IDLE,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    FINISH
  } state_t;

  state_t        state;
  logic [M-1:0]  cur;
  logic [M-1:0]  y_reg;
  logic [KW-1:0] cnt;
  logic [TW-1:0] timer;

  // Single FSM: all outputs are registered and loaded on the edge that enters
  // the state in which they must be visible, so the enable pulse coincides
  // with the ISSUE cycle and the WAIT state never samples a done level that
  // was present during ISSUE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mul_enable <= 1'b0;
      mul_cfg    <= 1'b1;
      result     <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      cur        <= '0;
      y_reg      <= '0;
      cnt        <= '0;
      timer      <= '0;
    end else begin
      mul_enable <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur        <= x_in;
            y_reg      <= y_in;
            cnt        <= k_in;
            busy       <= 1'b1;
            timer      <= '0;
            mul_a      <= x_in;
            mul_enable <= 1'b1;
            if (k_in != '0) begin
              mul_b   <= ONE;
              mul_cfg <= 1'b0;
              state   <= SQ_ISSUE;
            end else begin
              mul_b   <= y_in;
              mul_cfg <= 1'b1;
              state   <= MUL_ISSUE;
            end
          end
        end

        SQ_ISSUE: begin
          // Operand bus already carries the working value; keep it pinned.
          mul_a <= cur;
          timer <= '0;
          state <= SQ_WAIT;
        end

        SQ_WAIT: begin
          if (mul_done) begin
            // cnt >= 1 here, so the decrement can never wrap.
            cur        <= mul_c;
            cnt        <= cnt - K_ONE;
            timer      <= '0;
            mul_a      <= mul_c;
            mul_enable <= 1'b1;
            if (cnt != K_ONE) begin
              mul_b   <= ONE;
              mul_cfg <= 1'b0;
              state   <= SQ_ISSUE;
            end else begin
              mul_b   <= y_reg;
              mul_cfg <= 1'b1;
              state   <= MUL_ISSUE;
            end
          end else if (timer == TO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        MUL_ISSUE: begin
          mul_a <= cur;
          timer <= '0;
          state <= MUL_WAIT;
        end

        MUL_WAIT: begin
          if (mul_done) begin
            result <= mul_c;
            state  <= FINISH;
          end else if (timer == TO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp2k_mul_seq.sv
// Testbench for exp2k_mul_seq: an acb stub computes GF(2^163) square/multiply,
// a driver issues requests and pushes expectations into a scoreboard queue,
// and a monitor pops and compares on every done/err pulse.
module tb_exp2k_mul_seq;

  localparam int M        = 163;
  localparam int KW       = 8;
  localparam int WAIT_MAX = 1023;
  localparam logic [M-1:0] RED = M'(8'hC9);  // x^7 + x^6 + x^3 + 1
  localparam logic [M-1:0] ONE = M'(1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [M-1:0]  x_in, y_in;
  logic [KW-1:0] k_in;
  logic          busy, done, err;
  logic [M-1:0]  result, mul_a, mul_b;
  logic          mul_enable, mul_cfg;
  logic [M-1:0]  mul_c;
  logic          mul_done;

  exp2k_mul_seq #(.M(M), .KW(KW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in), .k_in(k_in),
    .busy(busy), .done(done), .err(err), .result(result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable), .mul_cfg(mul_cfg),
    .mul_c(mul_c), .mul_done(mul_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- field arithmetic ----------------
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    logic [M-1:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[M-1] ? ((aa << 1) ^ RED) : (aa << 1);
    end
    return r;
  endfunction

  // Squaring as bit interleave followed by top-down reduction.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) t[2*i] = a[i];
    for (int i = 2*M-2; i >= M; i--) begin
      if (t[i]) begin
        t[i] = 1'b0;
        t = t ^ ((2*M-1)'(RED) << (i - M));
      end
    end
    return t[M-1:0];
  endfunction

  function automatic logic [M-1:0] model(input logic [M-1:0] x, input logic [M-1:0] y,
                                         input int k);
    logic [M-1:0] r;
    r = x;
    for (int i = 0; i < k; i++) r = gf_mul(r, r);
    return gf_mul(r, y);
  endfunction

  function automatic logic [M-1:0] rand_fe();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[M-1:0];
  endfunction

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic         is_err;
    logic [M-1:0] res;
    int           k;
    int           lat;
    int           t0;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  int           last_en_cyc = 0;
  int           en_cnt   = 0;
  int           cfg_bad  = 0;
  int           cur_k    = 0;
  logic [M-1:0] cur_y    = '0;
  logic [M-1:0] last_res = '0;
  int           stub_lat = 1;
  logic         stub_dead = 1'b0;
  bit           chk_busy = 1'b0;

  task automatic check_v(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- acb stub ----------------
  int           rem = 0;
  logic [M-1:0] pend_c = '0;
  initial begin
    mul_c    = '0;
    mul_done = 1'b0;
  end
  always @(posedge clk) begin
    if (!rst) begin
      rem      <= 0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      if (mul_enable && !stub_dead) begin
        rem    <= stub_lat;
        pend_c <= mul_cfg ? gf_mul(mul_a, mul_b) : gf_sq(mul_a);
      end else if (rem != 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          mul_done <= 1'b1;
          mul_c    <= pend_c;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_busy) begin
        check_i("busy_after_end", int'(busy), 0);
        chk_busy = 1'b0;
      end
      if (rst && mul_enable) begin
        if (en_cnt < cur_k) begin
          if (mul_cfg !== 1'b0 || mul_b !== ONE) cfg_bad++;
        end else begin
          if (mul_cfg !== 1'b1 || mul_b !== cur_y) cfg_bad++;
        end
        en_cnt++;
        last_en_cyc = cyc;
      end
      if (rst && (done || err)) begin
        if (sb.size() == 0) begin
          check_i("spurious_end", int'({done, err}), 0);
        end else begin
          e = sb.pop_front();
          if (e.is_err) begin
            check_i("err_pulse", int'({done, err}), 1);
            check_i("err_time", cyc - last_en_cyc, WAIT_MAX);
            check_v("err_result_kept", result, e.res);
          end else begin
            check_i("done_pulse", int'({done, err}), 2);
            check_v("result", result, e.res);
            check_i("latency", cyc - e.t0, (e.k + 1) * (e.lat + 2) + 2);
            check_i("enable_count", en_cnt, e.k + 1);
            check_i("cfg_sequence_bad", cfg_bad, 0);
          end
          chk_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      check_i("idle_timeout", n, 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [M-1:0] x, input logic [M-1:0] y, input int k,
                        input int lat, input bit expect_err);
    exp_t e;
    wait_idle();
    stub_lat = lat;
    cur_k    = k;
    cur_y    = y;
    en_cnt   = 0;
    cfg_bad  = 0;
    e.is_err = expect_err;
    e.k      = k;
    e.lat    = lat;
    e.t0     = cyc;
    if (expect_err) e.res = last_res;
    else begin
      e.res    = model(x, y, k);
      last_res = e.res;
    end
    sb.push_back(e);
    x_in  = x;
    y_in  = y;
    k_in  = KW'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    k_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_done", int'(done), 0);
    check_i("rst_err", int'(err), 0);
    check_i("rst_enable", int'(mul_enable), 0);
    check_i("rst_cfg", int'(mul_cfg), 1);
    check_v("rst_result", result, '0);
    check_v("rst_mul_a", mul_a, '0);
    check_v("rst_mul_b", mul_b, '0);
    @(posedge clk); #1;

    // Directed cases
    run_op(M'(2), M'(1), 1, 3, 1'b0);
    wait_idle();
    check_v("x_sq_is_0x4", last_res, M'(4));
    run_op(M'(3), M'(5), 0, 2, 1'b0);
    run_op(M'(2), M'(1), 8, 1, 1'b0);

    // Second start while busy must be ignored
    run_op(M'(2), M'(1), 3, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    x_in  = M'(7);
    y_in  = M'(9);
    k_in  = KW'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check_v("busy_start_ignored", last_res, M'(256));

    // Timeout: stub never answers
    stub_dead = 1'b1;
    run_op(rand_fe(), rand_fe(), 0, 1, 1'b1);
    wait_idle();
    stub_dead = 1'b0;

    // Reset while in SQ_WAIT
    run_op(rand_fe(), rand_fe(), 5, 3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst      = 1'b1;
    last_res = '0;
    @(negedge clk);
    check_i("midrst_busy", int'(busy), 0);
    check_i("midrst_enable", int'(mul_enable), 0);
    check_i("midrst_done", int'(done), 0);
    check_v("midrst_result", result, '0);
    run_op(M'(2), M'(1), 2, 2, 1'b0);
    wait_idle();
    check_v("after_rst_0x10", result, M'(16));

    // Maximum K
    run_op(rand_fe(), rand_fe(), 255, 1, 1'b0);

    // Randomized requests
    for (int i = 0; i < 12; i++) begin
      run_op(rand_fe(), rand_fe(), int'($urandom_range(0, 12)), int'($urandom_range(1, 4)), 1'b0);
    end
    wait_idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
